aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Hardware sequencer that issues the AES-128 operation stream (pack, AddRoundKey, SubBytes/ShiftRows, MixColumns, unpack) to the vector AES datapath.
- Computes the round-key byte address for each AddRoundKey.
- Sits between the core's AES control register and the vector AES unit, so a full block encrypt or decrypt runs without instruction fetch.
- One op per valid/ready handshake.

Parameters:
- RK_BASE, 32'h0000_0058, byte address of round key 0 in data memory; key r is at RK_BASE + 16*r.
- NR, 10, number of rounds (AES-128); the round counter is 4 bits wide.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle request to begin a block operation
- decrypt  in  1  0 = encrypt, 1 = decrypt; sampled when start is accepted
- op_valid  out  1  op_code/rk_addr are valid
- op_ready  in  1  datapath accepts the current op
- op_code  out  4  0 NOP, 1 QPA, 2 ARK, 3 ESRSB, 4 EMIX, 5 DSRSU, 6 DMIX, 7 QPB, 8 KLOAD, 9 KEXP
- rk_addr  out  32  round-key byte address; meaningful for ARK, KLOAD, KEXP
- rcon  out  8  round constant for KEXP, else 0
- round  out  4  current round index
- busy  out  1  high from start acceptance until the done pulse inclusive
- done  out  1  one-cycle pulse after the final op's handshake

Behaviour:
- Reset values:
  - state IDLE
  - op_valid=0, op_code=0, rk_addr=0, rcon=0, round=0, busy=0, done=0
- Handshake:
  - An op completes on a cycle where op_valid & op_ready are both high.
  - While op_valid & !op_ready, op_code, rk_addr, rcon and round are held stable.
  - op_valid never drops without a handshake, except on reset.
- Start acceptance:
  - start is accepted only in IDLE; the cycle after, op_valid=1 with the first op.
  - start while busy is ignored.
  - decrypt is latched at acceptance; later changes have no effect.
- Encrypt stream, 32 ops:
  - QPA, then ARK(k0).
  - For r=1..9: ESRSB, EMIX, ARK(kr).
  - Then ESRSB, ARK(k10), QPB.
- Decrypt stream, 32 ops:
  - QPA, ARK(k10), DSRSU.
  - For r=9..1: ARK(kr), DMIX, DSRSU.
  - Then ARK(k0), QPB.
- States: IDLE, PRE, ARK_FIRST, RND_A, RND_B, RND_C, FIN_A, FIN_B, POST, DONE, plus KLOAD_S and KEXP_S when the optional feature is compiled in.
- Transitions advance only on handshake. RND_C either loops to RND_A or exits to FIN_A when the round counter reaches its terminal value (9 for encrypt, 1 for decrypt).
- Round and address:
  - round increments on encrypt and decrements on decrypt.
  - rk_addr = RK_BASE + {round,4'b0}, a 32-bit add with no wrap checking.
  - For non-key ops, rk_addr holds its last value.
- Completion:
  - POST handshake moves to DONE; DONE drives done=1 and op_valid=0 for one cycle, then returns to IDLE.
  - busy falls together with the return to IDLE.
  - Back-to-back: a start in the cycle after DONE (state IDLE) is accepted.
- Reset mid-operation returns to IDLE immediately, all outputs at reset values, no done pulse.

Optional Feature:
- Macro: AES_SEQ_KEYEXP_EN.
- With the macro defined:
  - An additional input key_expand (1 bit) is sampled at start acceptance.
  - If key_expand=1, the block op is preceded by KLOAD (rk_addr=RK_BASE) and then KEXP for i=1..10.
  - Each KEXP has rk_addr = RK_BASE + 16*i and rcon = 01,02,04,08,10,20,40,80,1B,36.
  - This adds 11 ops before QPA; round is reset before PRE.
  - If key_expand=0, there is no extra phase.
- Without the macro: the key_expand port does not exist, the KEXP/KLOAD codes are never issued, and rcon is tied to 0.

Test Plan:
- Encrypt, op_ready tied 1, start at cycle 0 -> 32 ops with codes 1,2,(3,4,2)x9,3,2,7; ARK rk_addr sequence 0x58,0x68,...,0xF8; done pulses at cycle 33; busy high cycles 1-33.
- Decrypt, op_ready tied 1 -> first ARK rk_addr=0xF8, last ARK rk_addr=0x58; codes 1,2,5,(2,6,5)x9,2,7; done after 32 handshakes.
- Backpressure: op_ready low for 5 cycles on the 4th op -> op_code=4 (EMIX) and rk_addr held all 5 cycles; total latency 33+5 cycles.
- start asserted while busy, and decrypt toggled mid-run -> ignored; the stream is unchanged.
- rst pulsed during round 5 -> next cycle op_valid=0, busy=0, round=0, no done; a fresh start runs a full 32-op stream.
- With AES_SEQ_KEYEXP_EN and key_expand=1 -> KLOAD@0x58, then KEXP rcon 01..36 at 0x68..0xF8, then the 32-op encrypt stream; done after 43 handshakes.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Issues the AES-128 encrypt/decrypt op stream to the vector AES datapath, one op per valid/ready handshake.
// Optional key-expansion prologue (KLOAD + 10x KEXP) is compiled in with AES_SEQ_KEYEXP_EN.
module aes_round_sequencer #(
    parameter logic [31:0] RK_BASE = 32'h0000_0058,
    parameter int          NR      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
`ifdef AES_SEQ_KEYEXP_EN
    input  logic        key_expand,
`endif
    output logic        op_valid,
    input  logic        op_ready,
    output logic [3:0]  op_code,
    output logic [31:0] rk_addr,
    output logic [7:0]  rcon,
    output logic [3:0]  round,
    output logic        busy,
    output logic        done,
    output logic [3:0]  state_dbg
);
    // Handshake: an op completes on a cycle with op_valid & op_ready; while op_valid & !op_ready
    // op_code, rk_addr, rcon and round stay stable, and op_valid only drops after a handshake.
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_QPA   = 4'd1;
    localparam logic [3:0] OP_ARK   = 4'd2;
    localparam logic [3:0] OP_ESRSB = 4'd3;
    localparam logic [3:0] OP_EMIX  = 4'd4;
    localparam logic [3:0] OP_DSRSU = 4'd5;
    localparam logic [3:0] OP_DMIX  = 4'd6;
    localparam logic [3:0] OP_QPB   = 4'd7;
    localparam logic [3:0] OP_KLOAD = 4'd8;
    localparam logic [3:0] OP_KEXP  = 4'd9;

    localparam logic [3:0] RND_LAST = 4'(NR);
    localparam logic [3:0] ENC_TERM = 4'(NR - 1);
    localparam logic [3:0] DEC_TERM = 4'd1;

    typedef enum logic [3:0] {
        IDLE, PRE, ARK_FIRST, RND_A, RND_B, RND_C, FIN_A, FIN_B, POST, DONE, KLOAD_S, KEXP_S
    } state_t;

    state_t      state, state_n;
    logic [3:0]  round_n;
    logic        dec_q;
    logic        hs;
    logic        key_n;
    logic        load_addr;
    logic [3:0]  round_step;

    assign hs         = op_valid && op_ready;
    assign round_step = dec_q ? round - 4'd1 : round + 4'd1;

    // Decrypt swaps the roles of RND_B/RND_C: the AddRoundKey sits in RND_B instead of RND_C.
    always_comb begin
        key_n = 1'b0;
        case (state_n)
            KLOAD_S, KEXP_S, ARK_FIRST, FIN_B: key_n = 1'b1;
            RND_B:                             key_n = dec_q;
            RND_C:                             key_n = !dec_q;
            default:                           key_n = 1'b0;
        endcase
    end

    assign load_addr = key_n && ((state_n != state) || hs);

    always_comb begin
        state_n = state;
        round_n = round;
        case (state)
            IDLE: begin
                if (start) begin
                    round_n = decrypt ? RND_LAST : 4'd0;
                    state_n = PRE;
`ifdef AES_SEQ_KEYEXP_EN
                    if (key_expand) begin
                        round_n = 4'd0;
                        state_n = KLOAD_S;
                    end
`endif
                end
            end
            KLOAD_S: if (hs) begin
                state_n = KEXP_S;
                round_n = round + 4'd1;
            end
            KEXP_S: if (hs) begin
                if (round == RND_LAST) begin
                    state_n = PRE;
                    round_n = dec_q ? RND_LAST : 4'd0;
                end else begin
                    round_n = round + 4'd1;
                end
            end
            PRE:       if (hs) state_n = ARK_FIRST;
            ARK_FIRST: if (hs) begin
                state_n = RND_A;
                round_n = round_step;
            end
            RND_A:     if (hs) state_n = RND_B;
            RND_B:     if (hs) state_n = RND_C;
            RND_C: if (hs) begin
                state_n = (round == (dec_q ? DEC_TERM : ENC_TERM)) ? FIN_A : RND_A;
                round_n = round_step;
            end
            FIN_A:     if (hs) state_n = FIN_B;
            FIN_B:     if (hs) state_n = POST;
            POST:      if (hs) state_n = DONE;
            DONE:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round   <= 4'd0;
            rk_addr <= 32'd0;
            dec_q   <= 1'b0;
        end else begin
            round <= round_n;
            if (state == IDLE && start) dec_q <= decrypt;
            if (load_addr) rk_addr <= RK_BASE + {24'd0, round_n, 4'b0000};
        end
    end

    always_comb begin
        op_code = OP_NOP;
        case (state)
            PRE:       op_code = OP_QPA;
            ARK_FIRST: op_code = OP_ARK;
            RND_A:     op_code = dec_q ? OP_DSRSU : OP_ESRSB;
            RND_B:     op_code = dec_q ? OP_ARK : OP_EMIX;
            RND_C:     op_code = dec_q ? OP_DMIX : OP_ARK;
            FIN_A:     op_code = dec_q ? OP_DSRSU : OP_ESRSB;
            FIN_B:     op_code = OP_ARK;
            POST:      op_code = OP_QPB;
            KLOAD_S:   op_code = OP_KLOAD;
            KEXP_S:    op_code = OP_KEXP;
            default:   op_code = OP_NOP;
        endcase
    end

`ifdef AES_SEQ_KEYEXP_EN
    function automatic logic [7:0] rcon_of(input logic [3:0] i);
        case (i)
            4'd1:    rcon_of = 8'h01;
            4'd2:    rcon_of = 8'h02;
            4'd3:    rcon_of = 8'h04;
            4'd4:    rcon_of = 8'h08;
            4'd5:    rcon_of = 8'h10;
            4'd6:    rcon_of = 8'h20;
            4'd7:    rcon_of = 8'h40;
            4'd8:    rcon_of = 8'h80;
            4'd9:    rcon_of = 8'h1B;
            4'd10:   rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

    assign rcon = (state == KEXP_S) ? rcon_of(round) : 8'h00;
`else
    assign rcon = 8'h00;
`endif

    assign op_valid  = (state != IDLE) && (state != DONE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// Randomized bench for aes_round_sequencer: expected op streams built from the AES-128 op ordering,
// checked every cycle; covers latency, backpressure, ignored start/decrypt, mid-run reset, key expansion.
module tb_aes_round_sequencer;
    localparam logic [31:0] RK_BASE = 32'h0000_0058;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic [31:0] rk_addr;
    logic [7:0]  rcon;
    logic [3:0]  round;
    logic        busy;
    logic        done;
    logic [3:0]  state_dbg;
`ifdef AES_SEQ_KEYEXP_EN
    logic        key_expand;
`endif

    int n_checks = 0;
    int n_err    = 0;

    // Expected op: [47:44] code, [43:36] rcon, [35:4] rk_addr, [3:0] key index
    logic [47:0] exp_q[$];
    logic [31:0] last_addr;
    logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    always #5 clk = ~clk;

    aes_round_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .decrypt   (decrypt),
`ifdef AES_SEQ_KEYEXP_EN
        .key_expand(key_expand),
`endif
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_code   (op_code),
        .rk_addr   (rk_addr),
        .rcon      (rcon),
        .round     (round),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_key(input logic [3:0] code);
        return (code == 4'd2) || (code == 4'd8) || (code == 4'd9);
    endfunction

    task automatic push_op(input logic [3:0] code, input logic [3:0] key_idx, input logic [7:0] rc);
        if (is_key(code)) last_addr = RK_BASE + 32'(key_idx) * 32'd16;
        exp_q.push_back({code, rc, last_addr, key_idx});
    endtask

    task automatic build_stream(input bit dec, input bit kx);
        if (kx) begin
            push_op(4'd8, 4'd0, 8'h00);
            for (int i = 1; i <= 10; i++) push_op(4'd9, 4'(i), rcon_tab[i-1]);
        end
        push_op(4'd1, 4'd0, 8'h00);
        if (!dec) begin
            push_op(4'd2, 4'd0, 8'h00);
            for (int r = 1; r <= 9; r++) begin
                push_op(4'd3, 4'd0, 8'h00);
                push_op(4'd4, 4'd0, 8'h00);
                push_op(4'd2, 4'(r), 8'h00);
            end
            push_op(4'd3, 4'd0, 8'h00);
            push_op(4'd2, 4'd10, 8'h00);
            push_op(4'd7, 4'd0, 8'h00);
        end else begin
            push_op(4'd2, 4'd10, 8'h00);
            push_op(4'd5, 4'd0, 8'h00);
            for (int r = 9; r >= 1; r--) begin
                push_op(4'd2, 4'(r), 8'h00);
                push_op(4'd6, 4'd0, 8'h00);
                push_op(4'd5, 4'd0, 8'h00);
            end
            push_op(4'd2, 4'd0, 8'h00);
            push_op(4'd7, 4'd0, 8'h00);
        end
    endtask

    // mode 0: ready tied 1; 1: random ready; 2: ready low 5 cycles on 4th op; 3: random ready + start/decrypt noise.
    // Called at a negedge; start is driven immediately so a call right after DONE tests back-to-back start.
    task automatic run_block(input bit dec, input bit kx, input int mode, input int abort_at,
                             output int done_cyc);
        int          hs;
        int          bp;
        logic [47:0] e;
        hs = 0;
        bp = 0;
        done_cyc = -1;
        build_stream(dec, kx);
        start   = 1'b1;
        decrypt = dec;
`ifdef AES_SEQ_KEYEXP_EN
        key_expand = kx;
`endif
        op_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            if (cyc > 1) @(negedge clk);
            if (abort_at >= 0 && hs == abort_at) begin
                rst      = 1'b1;
                op_ready = 1'b0;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                check("rst_op_valid", op_valid, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_round", round, 4'd0);
                check("rst_done", done, 1'b0);
                check("rst_rk_addr", rk_addr, 32'd0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("rst_no_done", done, 1'b0);
                end
                exp_q.delete();
                last_addr = 32'd0;
                done_cyc  = -2;
                return;
            end
            if (exp_q.size() > 0) begin
                case (mode)
                    0: op_ready = 1'b1;
                    2: begin
                        op_ready = !(hs == 3 && bp < 5);
                        if (!op_ready) bp++;
                    end
                    default: op_ready = ($urandom_range(0, 3) != 0);
                endcase
                if (mode == 3) begin
                    start   = 1'($urandom_range(0, 1));
                    decrypt = 1'($urandom_range(0, 1));
                end
                e = exp_q[0];
                check("busy", busy, 1'b1);
                check("done_early", done, 1'b0);
                check("op_valid", op_valid, 1'b1);
                if (!op_valid) break;
                check("op_code", op_code, e[47:44]);
                check("rk_addr", rk_addr, e[35:4]);
                check("rcon", rcon, e[43:36]);
                if (is_key(e[47:44])) check("round", round, e[3:0]);
                if (op_ready) begin
                    void'(exp_q.pop_front());
                    hs++;
                end
            end else begin
                start = 1'b0;
                check("done", done, 1'b1);
                check("op_valid_at_done", op_valid, 1'b0);
                check("busy_at_done", busy, 1'b1);
                done_cyc = cyc;
                @(negedge clk);
                check("busy_after_done", busy, 1'b0);
                check("done_after_done", done, 1'b0);
                break;
            end
        end
        start = 1'b0;
        check("done_seen", (done_cyc >= 0), 1'b1);
        if (done_cyc < 0) begin
            exp_q.delete();
            @(negedge clk);
        end
    endtask

    initial begin
        int dc;
        rst       = 1'b1;
        start     = 1'b0;
        decrypt   = 1'b0;
        op_ready  = 1'b0;
        last_addr = 32'd0;
`ifdef AES_SEQ_KEYEXP_EN
        key_expand = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_op_valid", op_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_op_code", op_code, 4'd0);
        check("reset_rk_addr", rk_addr, 32'd0);
        check("reset_rcon", rcon, 8'd0);
        check("reset_round", round, 4'd0);
        rst = 1'b0;
        @(negedge clk);

        run_block(1'b0, 1'b0, 0, -1, dc);
        check("enc_done_cycle", dc, 33);
        run_block(1'b1, 1'b0, 0, -1, dc);
        check("dec_done_cycle", dc, 33);
        run_block(1'b0, 1'b0, 2, -1, dc);
        check("bp_done_cycle", dc, 38);
        run_block(1'b1, 1'b0, 3, -1, dc);
        run_block(1'b0, 1'b0, 3, -1, dc);
        run_block(1'b0, 1'b0, 0, 14, dc);
        run_block(1'b0, 1'b0, 0, -1, dc);
        check("post_rst_done_cycle", dc, 33);
        for (int i = 0; i < 4; i++) run_block(1'($urandom_range(0, 1)), 1'b0, 1, -1, dc);
`ifdef AES_SEQ_KEYEXP_EN
        run_block(1'b0, 1'b1, 0, -1, dc);
        check("kexp_done_cycle", dc, 44);
        run_block(1'b1, 1'b1, 1, -1, dc);
        run_block(1'b0, 1'b0, 0, -1, dc);
        check("no_kexp_done_cycle", dc, 33);
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
